csr_unit: RTL and testbench
===========================

# csr_unit

Machine/supervisor CSR file for the RV64 core: holds the trap, status, delegation, counter and translation registers, decides trap targets, and produces the registered PC redirect for traps and xRET. It sits beside the writeback stage. Events arrive as single-cycle pulses, one per retired instruction, rather than being detected by comparing counters. It generalises the earlier M-only file with S-mode delegation, vectored interrupts, a parametric number of HPM counters and privilege-checked access.

## Interface
- XLEN, 64, register width
- NUM_HPM, 4, number of mhpmcounter3.. counters (0..29)
- SUPPORT_SMODE, 1, 0 makes all S-mode/delegation CSRs read 0 and ignore writes
- HART_ID, 0, mhartid reset/constant value

Ports:
- clk  in  1  clock
- rst  in  1  reset rst, asynchronous, active-high
- retire_valid  in  1  one pulse per retired instruction
- csr_we  in  1  CSR write, qualified by retire_valid
- csr_addr  in  12  read/write address
- csr_wdata  in  XLEN  final write value (RW/RS/RC already resolved)
- csr_rdata  out  XLEN  combinational read of csr_addr
- csr_illegal  out  1  combinational: csr_addr nonexistent, privilege too low, or csr_we to read-only (addr[11:10]==3)
- trap_valid  in  1  exception/interrupt taken at this retire
- trap_is_int  in  1  interrupt (1) / exception (0)
- trap_code  in  6  cause code
- trap_pc  in  XLEN  epc value
- trap_tval  in  XLEN  tval value
- xret_valid  in  1  mret/sret
- xret_is_sret  in  1  selects sret
- irq_ext, irq_timer, irq_soft  in  1 each  level-sensitive M-level interrupt lines into mip.MEIP/MTIP/MSIP
- hpm_event  in  NUM_HPM  per-counter increment strobes
- irq_pending  out  1  an enabled interrupt is takeable
- irq_code  out  6  highest-priority takeable cause
- redirect_valid  out  1  registered, one-cycle pulse
- redirect_pc  out  XLEN  registered target
- pmode  out  2  current privilege (0 U, 1 S, 3 M)
- satp_o, mstatus_o  out  XLEN  live values for MMU

## Operation
- Per-cycle event priority: trap_valid > xret_valid > csr_we. A lower event in the same cycle is dropped; retire_valid still counts.
- Delegation:
  - A trap goes to S when SUPPORT_SMODE, pmode<=1, and medeleg[code] (exception) or mideleg[code] (interrupt) is set; otherwise it goes to M.
- M trap entry:
  - mepc<=trap_pc & ~1; mcause<={trap_is_int,57'b0,code}; mtval<=trap_tval.
  - MPIE<=MIE, MIE<=0, MPP<=pmode, pmode<=3.
- S trap entry:
  - sepc, scause, stval updated likewise.
  - SPIE<=SIE, SIE<=0, SPP<=pmode[0], pmode<=1.
- Target: tvec base (tvec & ~3). If tvec[1:0]==1 and it is an interrupt, target is base + 4*code.
- mret:
  - pmode<=MPP, MIE<=MPIE, MPIE<=1, MPP<=0; target mepc.
  - If pmode!=3, treated as an illegal-instruction trap instead: code 2, tval 0, epc trap_pc.
- sret:
  - pmode<=SPP, SIE<=SPIE, SPIE<=1, SPP<=0; target sepc.
  - Illegal (as above) if pmode==0 or SUPPORT_SMODE==0.
- CSR write, only when csr_we & retire_valid & !csr_illegal:
  - mstatus writable mask: SIE, MIE, SPIE, MPIE, SPP, MPP, SUM, MXR. MPP written as 2 stores 0.
  - sstatus is a masked view of mstatus: SIE, SPIE, SPP, SUM, MXR.
  - sie and sip are views of mie and mip masked by mideleg.
  - mip: only SSIP, STIP, SEIP are writable; MEIP, MTIP, MSIP follow the input lines every cycle.
  - tvec: bit 1 forced 0.
  - mhartid, misa: read-only.
- Counters wrap modulo 2^64:
  - mcycle +1 every cycle.
  - minstret +1 per retire_valid.
  - hpm[i] +1 per hpm_event[i].
  - A CSR write to a counter replaces that cycle's increment.
- irq_pending: pend = mip & mie.
  - M set: ~mideleg & pend; takeable if pmode<3 or MIE.
  - S set: mideleg & pend; takeable if pmode<1, or pmode==1 & SIE.
  - Priority: MEI(11) > MSI(3) > MTI(7) > SEI(9) > SSI(1) > STI(5). M set beats S set.
  - irq_code = winning cause; 0 when none is takeable.

## Timing
- All state updates on the clk edge of the event cycle. csr_rdata, csr_illegal, irq_pending and irq_code are combinational from current state.
- redirect_valid/redirect_pc are asserted the cycle after trap_valid/xret_valid, for exactly one cycle.
- A read in the cycle after a write returns the new value. There is no same-cycle bypass.
- Reset (asynchronous, any cycle, including mid-redirect):
  - pmode=3, redirect_valid=0, redirect_pc=0.
  - All CSRs 0 except mhartid=HART_ID and misa = constant (MXL=2, I, M, A, plus S/U when SUPPORT_SMODE).
  - A pending redirect is cancelled.
- Back-to-back traps on consecutive cycles are each taken; the second sees the state written by the first (e.g. MPP=3).

## Test plan
- Reset, then read mhartid/mstatus/pmode -> HART_ID, 0, 3. redirect_valid stays 0.
- pmode=0, mtvec=0x8000_0001, mie.MTIE=1, irq_timer=1 -> irq_pending=1, irq_code=7. trap_valid(int,7,pc=0x1000) -> next cycle redirect_pc=0x8000_001C, mcause=0x8000_0000_0000_0007, mepc=0x1000, MPP=0, pmode=3.
- medeleg[8]=1, pmode=0, ecall trap (code 8, pc=0x2004) -> sepc=0x2004, scause=8, SPP=0, pmode=1, redirect_pc=stvec. mepc unchanged.
- From S, mret -> illegal trap: mcause=2, pmode=3. Then in M with MPP=1, MPIE=1: mret -> pmode=1, MIE=1, MPIE=1, MPP=0, redirect_pc=mepc.
- Write mcycle=0xFFFF_FFFF_FFFF_FFFF -> next cycle reads that value, the following cycle reads 0. The minstret write cycle suppresses that cycle's increment.
- From U, csr_we to mstatus -> csr_illegal=1, no state change. Write mstatus with MPP=2 in M -> MPP reads 0.

Source files
------------

// File: rtl/csr_unit.sv
// Machine/supervisor CSR file for the RV64 core: trap, status, delegation, counter and
// translation state, trap-target selection and the registered PC redirect for traps/xRET.
module csr_unit #(
    parameter int              XLEN          = 64,
    parameter int              NUM_HPM       = 4,
    parameter bit              SUPPORT_SMODE = 1'b1,
    parameter logic [XLEN-1:0] HART_ID       = '0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   retire_valid,
    input  logic                                   csr_we,
    input  logic [11:0]                            csr_addr,
    input  logic [XLEN-1:0]                        csr_wdata,
    output logic [XLEN-1:0]                        csr_rdata,
    output logic                                   csr_illegal,
    input  logic                                   trap_valid,
    input  logic                                   trap_is_int,
    input  logic [5:0]                             trap_code,
    input  logic [XLEN-1:0]                        trap_pc,
    input  logic [XLEN-1:0]                        trap_tval,
    input  logic                                   xret_valid,
    input  logic                                   xret_is_sret,
    input  logic                                   irq_ext,
    input  logic                                   irq_timer,
    input  logic                                   irq_soft,
    input  logic [(NUM_HPM > 0 ? NUM_HPM : 1)-1:0] hpm_event,
    output logic                                   irq_pending,
    output logic [5:0]                             irq_code,
    output logic                                   redirect_valid,
    output logic [XLEN-1:0]                        redirect_pc,
    output logic [1:0]                             pmode,
    output logic [XLEN-1:0]                        satp_o,
    output logic [XLEN-1:0]                        mstatus_o
);
    localparam int HPM_W = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam logic [1:0] PRV_U = 2'd0, PRV_S = 2'd1, PRV_M = 2'd3;

    localparam int B_SIE = 1, B_MIE = 3, B_SPIE = 5, B_MPIE = 7, B_SPP = 8;
    localparam int B_MPP_LO = 11, B_MPP_HI = 12;

    localparam logic [XLEN-1:0] ONE           = XLEN'(1);
    localparam logic [XLEN-1:0] SSTATUS_MASK  = XLEN'(64'h0000_0000_000C_0122);
    localparam logic [XLEN-1:0] MSTATUS_WMASK = SUPPORT_SMODE ? XLEN'(64'h0000_0000_000C_19AA)
                                                              : XLEN'(64'h0000_0000_0000_1888);
    localparam logic [XLEN-1:0] S_IRQ_MASK    = SUPPORT_SMODE ? XLEN'(64'h222) : '0;
    localparam logic [XLEN-1:0] MIE_WMASK     = XLEN'(64'h888) | S_IRQ_MASK;
    localparam logic [XLEN-1:0] MEDELEG_MASK  = SUPPORT_SMODE ? XLEN'(64'hB3FF) : '0;
    localparam logic [25:0]     MISA_EXT      = 26'h000_1101 | (SUPPORT_SMODE ? 26'h014_0000 : 26'h0);
    localparam logic [XLEN-1:0] MISA_VAL      = {2'b10, {(XLEN-28){1'b0}}, MISA_EXT};

    localparam logic [11:0] A_SSTATUS = 12'h100, A_SIE = 12'h104, A_STVEC = 12'h105;
    localparam logic [11:0] A_SSCRATCH = 12'h140, A_SEPC = 12'h141, A_SCAUSE = 12'h142;
    localparam logic [11:0] A_STVAL = 12'h143, A_SIP = 12'h144, A_SATP = 12'h180;
    localparam logic [11:0] A_MSTATUS = 12'h300, A_MISA = 12'h301, A_MEDELEG = 12'h302;
    localparam logic [11:0] A_MIDELEG = 12'h303, A_MIE = 12'h304, A_MTVEC = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340, A_MEPC = 12'h341, A_MCAUSE = 12'h342;
    localparam logic [11:0] A_MTVAL = 12'h343, A_MIP = 12'h344;
    localparam logic [11:0] A_MCYCLE = 12'hB00, A_MINSTRET = 12'hB02, A_MHPM3 = 12'hB03;
    localparam logic [11:0] A_CYCLE = 12'hC00, A_INSTRET = 12'hC02, A_HPM3 = 12'hC03;
    localparam logic [11:0] A_MHARTID = 12'hF14;

    logic [XLEN-1:0] mstatus, medeleg, mideleg, mie, mip_sw, mtvec, mscratch, mepc, mcause, mtval;
    logic [XLEN-1:0] stvec, sscratch, sepc, scause, stval, satp;
    logic [XLEN-1:0] mcycle, minstret;
    logic [XLEN-1:0] hpm [HPM_W];
    logic [2:0]      mip_line;
    logic [XLEN-1:0] mip_rd;

    assign satp_o    = satp;
    assign mstatus_o = mstatus;

    always_comb begin
        mip_rd     = mip_sw;
        mip_rd[11] = mip_line[2];
        mip_rd[7]  = mip_line[1];
        mip_rd[3]  = mip_line[0];
    end

    // Read mux and existence decode; privilege and read-only checks are layered on top.
    logic csr_exists;
    always_comb begin
        csr_rdata  = '0;
        csr_exists = 1'b1;
        case (csr_addr)
            A_SSTATUS:             csr_rdata = mstatus & SSTATUS_MASK;
            A_SIE:                 csr_rdata = mie & mideleg;
            A_STVEC:               csr_rdata = stvec;
            A_SSCRATCH:            csr_rdata = sscratch;
            A_SEPC:                csr_rdata = sepc;
            A_SCAUSE:              csr_rdata = scause;
            A_STVAL:               csr_rdata = stval;
            A_SIP:                 csr_rdata = mip_rd & mideleg;
            A_SATP:                csr_rdata = satp;
            A_MSTATUS:             csr_rdata = mstatus;
            A_MISA:                csr_rdata = MISA_VAL;
            A_MEDELEG:             csr_rdata = medeleg;
            A_MIDELEG:             csr_rdata = mideleg;
            A_MIE:                 csr_rdata = mie;
            A_MTVEC:               csr_rdata = mtvec;
            A_MSCRATCH:            csr_rdata = mscratch;
            A_MEPC:                csr_rdata = mepc;
            A_MCAUSE:              csr_rdata = mcause;
            A_MTVAL:               csr_rdata = mtval;
            A_MIP:                 csr_rdata = mip_rd;
            A_MCYCLE, A_CYCLE:     csr_rdata = mcycle;
            A_MINSTRET, A_INSTRET: csr_rdata = minstret;
            A_MHARTID:             csr_rdata = HART_ID;
            default: begin
                csr_exists = 1'b0;
                for (int i = 0; i < NUM_HPM; i++) begin
                    if (csr_addr == 12'(A_MHPM3 + i) || csr_addr == 12'(A_HPM3 + i)) begin
                        csr_exists = 1'b1;
                        csr_rdata  = hpm[i];
                    end
                end
            end
        endcase
    end

    assign csr_illegal = !csr_exists || (csr_addr[9:8] > pmode) ||
                         (csr_we && csr_addr[11:10] == 2'b11);

    // Event priority: trap > xret > CSR write. An illegal xret becomes an illegal-instruction trap.
    logic mret_ill, sret_ill, take_trap, do_mret, do_sret, csr_wr;
    assign mret_ill  = (pmode != PRV_M);
    assign sret_ill  = (pmode == PRV_U) || !SUPPORT_SMODE;
    assign take_trap = trap_valid || (xret_valid && (xret_is_sret ? sret_ill : mret_ill));
    assign do_mret   = !trap_valid && xret_valid && !xret_is_sret && !mret_ill;
    assign do_sret   = !trap_valid && xret_valid && xret_is_sret && !sret_ill;
    assign csr_wr    = csr_we && retire_valid && !csr_illegal && !trap_valid && !xret_valid;

    logic            t_int, trap_to_s, t_vect;
    logic [5:0]      t_code;
    logic [XLEN-1:0] t_epc, t_tval, t_cause, t_deleg, tvec_sel, trap_target;
    assign t_int       = trap_valid && trap_is_int;
    assign t_code      = trap_valid ? trap_code : 6'd2;
    assign t_tval      = trap_valid ? trap_tval : '0;
    assign t_epc       = trap_pc & ~ONE;
    assign t_cause     = {t_int, {(XLEN-7){1'b0}}, t_code};
    assign t_deleg     = t_int ? mideleg : medeleg;
    assign trap_to_s   = SUPPORT_SMODE && (pmode <= PRV_S) && t_deleg[t_code];
    assign tvec_sel    = trap_to_s ? stvec : mtvec;
    assign t_vect      = (tvec_sel[1:0] == 2'b01) && t_int;
    assign trap_target = {tvec_sel[XLEN-1:2], 2'b00} + (t_vect ? XLEN'({t_code, 2'b00}) : '0);

    logic [XLEN-1:0] mstatus_wval;
    always_comb begin
        mstatus_wval = csr_wdata & MSTATUS_WMASK;
        if (mstatus_wval[B_MPP_HI:B_MPP_LO] == 2'b10 ||
            (!SUPPORT_SMODE && mstatus_wval[B_MPP_HI:B_MPP_LO] == 2'b01))
            mstatus_wval[B_MPP_HI:B_MPP_LO] = PRV_U;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pmode          <= PRV_M;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            mip_line       <= '0;
            mstatus <= '0; medeleg <= '0; mideleg <= '0; mie <= '0; mip_sw <= '0;
            mtvec <= '0; mscratch <= '0; mepc <= '0; mcause <= '0; mtval <= '0;
            stvec <= '0; sscratch <= '0; sepc <= '0; scause <= '0; stval <= '0; satp <= '0;
        end else begin
            redirect_valid <= 1'b0;
            mip_line       <= {irq_ext, irq_timer, irq_soft};
            if (take_trap) begin
                redirect_valid <= 1'b1;
                redirect_pc    <= trap_target;
                if (trap_to_s) begin
                    sepc   <= t_epc;
                    scause <= t_cause;
                    stval  <= t_tval;
                    mstatus[B_SPIE] <= mstatus[B_SIE];
                    mstatus[B_SIE]  <= 1'b0;
                    mstatus[B_SPP]  <= pmode[0];
                    pmode           <= PRV_S;
                end else begin
                    mepc   <= t_epc;
                    mcause <= t_cause;
                    mtval  <= t_tval;
                    mstatus[B_MPIE]            <= mstatus[B_MIE];
                    mstatus[B_MIE]             <= 1'b0;
                    mstatus[B_MPP_HI:B_MPP_LO] <= pmode;
                    pmode                      <= PRV_M;
                end
            end else if (do_mret) begin
                redirect_valid             <= 1'b1;
                redirect_pc                <= mepc;
                pmode                      <= mstatus[B_MPP_HI:B_MPP_LO];
                mstatus[B_MIE]             <= mstatus[B_MPIE];
                mstatus[B_MPIE]            <= 1'b1;
                mstatus[B_MPP_HI:B_MPP_LO] <= PRV_U;
            end else if (do_sret) begin
                redirect_valid  <= 1'b1;
                redirect_pc     <= sepc;
                pmode           <= {1'b0, mstatus[B_SPP]};
                mstatus[B_SIE]  <= mstatus[B_SPIE];
                mstatus[B_SPIE] <= 1'b1;
                mstatus[B_SPP]  <= 1'b0;
            end else if (csr_wr) begin
                case (csr_addr)
                    A_MSTATUS:  mstatus  <= mstatus_wval;
                    A_MEDELEG:  medeleg  <= csr_wdata & MEDELEG_MASK;
                    A_MIDELEG:  mideleg  <= csr_wdata & S_IRQ_MASK;
                    A_MIE:      mie      <= csr_wdata & MIE_WMASK;
                    A_MIP:      mip_sw   <= csr_wdata & S_IRQ_MASK;
                    A_MTVEC:    mtvec    <= csr_wdata & ~XLEN'(2);
                    A_MSCRATCH: mscratch <= csr_wdata;
                    A_MEPC:     mepc     <= csr_wdata & ~ONE;
                    A_MCAUSE:   mcause   <= csr_wdata;
                    A_MTVAL:    mtval    <= csr_wdata;
                    A_SSTATUS:  if (SUPPORT_SMODE) mstatus <= (mstatus & ~SSTATUS_MASK) | (csr_wdata & SSTATUS_MASK);
                    A_SIE:      if (SUPPORT_SMODE) mie <= (mie & ~mideleg) | (csr_wdata & mideleg);
                    A_SIP:      if (SUPPORT_SMODE) mip_sw <= (mip_sw & ~mideleg) | (csr_wdata & mideleg);
                    A_STVEC:    if (SUPPORT_SMODE) stvec    <= csr_wdata & ~XLEN'(2);
                    A_SSCRATCH: if (SUPPORT_SMODE) sscratch <= csr_wdata;
                    A_SEPC:     if (SUPPORT_SMODE) sepc     <= csr_wdata & ~ONE;
                    A_SCAUSE:   if (SUPPORT_SMODE) scause   <= csr_wdata;
                    A_STVAL:    if (SUPPORT_SMODE) stval    <= csr_wdata;
                    A_SATP:     if (SUPPORT_SMODE) satp     <= csr_wdata;
                    default: ;
                endcase
            end
        end
    end

    // A CSR write to a counter takes the place of that cycle's increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcycle   <= '0;
            minstret <= '0;
            for (int i = 0; i < HPM_W; i++) hpm[i] <= '0;
        end else begin
            mcycle   <= (csr_wr && csr_addr == A_MCYCLE) ? csr_wdata : mcycle + ONE;
            if (csr_wr && csr_addr == A_MINSTRET) minstret <= csr_wdata;
            else if (retire_valid)                minstret <= minstret + ONE;
            for (int i = 0; i < NUM_HPM; i++) begin
                if (csr_wr && csr_addr == 12'(A_MHPM3 + i)) hpm[i] <= csr_wdata;
                else if (hpm_event[i])                      hpm[i] <= hpm[i] + ONE;
            end
        end
    end

    function automatic logic [5:0] pick_irq(input logic [XLEN-1:0] s);
        if (s[11]) return 6'd11;
        if (s[3])  return 6'd3;
        if (s[7])  return 6'd7;
        if (s[9])  return 6'd9;
        if (s[1])  return 6'd1;
        if (s[5])  return 6'd5;
        return 6'd0;
    endfunction

    logic [XLEN-1:0] pend, m_set, s_set;
    logic            m_take, s_take;
    assign pend   = mip_rd & mie;
    assign m_set  = pend & ~mideleg;
    assign s_set  = pend & mideleg;
    assign m_take = (|m_set) && (pmode != PRV_M || mstatus[B_MIE]);
    assign s_take = (|s_set) && (pmode == PRV_U || (pmode == PRV_S && mstatus[B_SIE]));

    assign irq_pending = m_take || s_take;
    assign irq_code    = m_take ? pick_irq(m_set) : (s_take ? pick_irq(s_set) : 6'd0);
endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit: reset, counters, access checks, traps,
// delegation, xRET, interrupt priority and reset during a pending redirect.
module tb_csr_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        retire_valid, csr_we, csr_illegal;
    logic [11:0] csr_addr;
    logic [63:0] csr_wdata, csr_rdata;
    logic        trap_valid, trap_is_int;
    logic [5:0]  trap_code;
    logic [63:0] trap_pc, trap_tval;
    logic        xret_valid, xret_is_sret;
    logic        irq_ext, irq_timer, irq_soft;
    logic [3:0]  hpm_event;
    logic        irq_pending;
    logic [5:0]  irq_code;
    logic        redirect_valid;
    logic [63:0] redirect_pc, satp_o, mstatus_o;
    logic [1:0]  pmode;

    int n_cmp = 0;
    int n_err = 0;

    csr_unit #(.XLEN(64), .NUM_HPM(4), .SUPPORT_SMODE(1'b1), .HART_ID(64'd5)) dut (
        .clk(clk), .rst(rst), .retire_valid(retire_valid), .csr_we(csr_we),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .csr_illegal(csr_illegal), .trap_valid(trap_valid), .trap_is_int(trap_is_int),
        .trap_code(trap_code), .trap_pc(trap_pc), .trap_tval(trap_tval),
        .xret_valid(xret_valid), .xret_is_sret(xret_is_sret), .irq_ext(irq_ext),
        .irq_timer(irq_timer), .irq_soft(irq_soft), .hpm_event(hpm_event),
        .irq_pending(irq_pending), .irq_code(irq_code), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .pmode(pmode), .satp_o(satp_o), .mstatus_o(mstatus_o)
    );

    always #10 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_csr(input string tag, input logic [11:0] a, input logic [63:0] exp);
        csr_addr = a;
        #1;
        check(tag, csr_rdata, exp);
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [63:0] d);
        csr_addr = a; csr_wdata = d; csr_we = 1'b1; retire_valid = 1'b1;
        @(negedge clk);
        csr_we = 1'b0; retire_valid = 1'b0;
        #1;
    endtask

    task automatic do_trap(input logic is_int, input logic [5:0] code,
                           input logic [63:0] pc, input logic [63:0] tval);
        trap_valid = 1'b1; trap_is_int = is_int; trap_code = code;
        trap_pc = pc; trap_tval = tval; retire_valid = 1'b1;
        @(negedge clk);
        trap_valid = 1'b0; retire_valid = 1'b0;
        #1;
    endtask

    task automatic do_xret(input logic is_sret, input logic [63:0] pc);
        xret_valid = 1'b1; xret_is_sret = is_sret; trap_pc = pc;
        trap_tval = 64'hDEAD; retire_valid = 1'b1;
        @(negedge clk);
        xret_valid = 1'b0; retire_valid = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        retire_valid = 0; csr_we = 0; csr_addr = '0; csr_wdata = '0;
        trap_valid = 0; trap_is_int = 0; trap_code = '0; trap_pc = '0; trap_tval = '0;
        xret_valid = 0; xret_is_sret = 0; irq_ext = 0; irq_timer = 0; irq_soft = 0;
        hpm_event = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;

        // Reset state
        check_csr("rst_mhartid", 12'hF14, 64'd5);
        check("rst_mhartid_legal", csr_illegal, 1'b0);
        check_csr("rst_mstatus", 12'h300, 64'h0);
        check_csr("rst_misa", 12'h301, 64'h8000_0000_0014_1101);
        check("rst_pmode", pmode, 2'd3);
        repeat (3) @(negedge clk);
        check("rst_redirect_idle", redirect_valid, 1'b0);

        // Counters: wrap, write-replaces-increment, HPM strobes
        csr_write(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
        check_csr("mcycle_written", 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk); #1;
        check_csr("mcycle_wrap", 12'hB00, 64'h0);
        csr_write(12'hB02, 64'd100);
        check_csr("minstret_write_no_inc", 12'hB02, 64'd100);
        retire_valid = 1'b1;
        repeat (3) @(negedge clk);
        retire_valid = 1'b0; #1;
        check_csr("minstret_count", 12'hC02, 64'd103);
        hpm_event = 4'b0101; @(negedge clk);
        hpm_event = 4'b0001; @(negedge clk);
        hpm_event = 4'b0000; #1;
        check_csr("hpm3", 12'hB03, 64'd2);
        check_csr("hpm5", 12'hB05, 64'd1);
        check_csr("hpm3_user_view", 12'hC03, 64'd2);
        csr_addr = 12'hB04; csr_wdata = 64'd50; csr_we = 1; retire_valid = 1; hpm_event = 4'b0010;
        @(negedge clk);
        csr_we = 0; retire_valid = 0; hpm_event = 4'b0000; #1;
        check_csr("hpm4_write_beats_event", 12'hB04, 64'd50);

        // Access checks and status masking in M
        csr_addr = 12'hF14; csr_we = 1'b1; #1;
        check("ro_write_illegal", csr_illegal, 1'b1);
        csr_we = 1'b0;
        csr_addr = 12'h7C0; #1;
        check("nonexistent_illegal", csr_illegal, 1'b1);
        csr_write(12'h300, 64'h1008);
        check_csr("mstatus_mpp2_to_0", 12'h300, 64'h8);
        csr_write(12'h300, 64'hFFFF_FFFF_FFFF_FFFF);
        check_csr("mstatus_wmask", 12'h300, 64'h000C_19AA);
        csr_write(12'h300, 64'h0);
        csr_write(12'h301, 64'h0);
        check_csr("misa_readonly", 12'h301, 64'h8000_0000_0014_1101);

        // Trap setup
        csr_write(12'h305, 64'h8000_0001);
        check_csr("mtvec", 12'h305, 64'h8000_0001);
        csr_write(12'h105, 64'h4000_0002);
        check_csr("stvec_bit1_forced", 12'h105, 64'h4000_0000);
        csr_write(12'h304, 64'h80);
        csr_write(12'h302, 64'h100);
        csr_write(12'h341, 64'h3000);

        // mret from M to U
        do_xret(1'b0, 64'h0);
        check("mret_u_redirect_valid", redirect_valid, 1'b1);
        check("mret_u_redirect_pc", redirect_pc, 64'h3000);
        check("mret_u_pmode", pmode, 2'd0);
        check("mret_u_mstatus", mstatus_o, 64'h80);

        // From U: write to mstatus is illegal and ignored
        csr_addr = 12'h300; csr_wdata = 64'h8; csr_we = 1; retire_valid = 1; #1;
        check("u_mstatus_illegal", csr_illegal, 1'b1);
        @(negedge clk);
        csr_we = 0; retire_valid = 0; #1;
        check("u_mstatus_unchanged", mstatus_o, 64'h80);
        check("redirect_one_cycle", redirect_valid, 1'b0);
        csr_addr = 12'h100; #1;
        check("u_sstatus_illegal", csr_illegal, 1'b1);

        // Vectored timer interrupt from U
        irq_timer = 1'b1;
        @(negedge clk); #1;
        check("tmr_pending", irq_pending, 1'b1);
        check("tmr_code", irq_code, 6'd7);
        do_trap(1'b1, 6'd7, 64'h1000, 64'h0);
        check("tmr_redirect_pc", redirect_pc, 64'h8000_001C);
        check("tmr_pmode", pmode, 2'd3);
        check("tmr_mstatus", mstatus_o, 64'h0);
        check("tmr_masked_in_m", irq_pending, 1'b0);
        check_csr("tmr_mcause", 12'h342, 64'h8000_0000_0000_0007);
        check_csr("tmr_mepc", 12'h341, 64'h1000);
        irq_timer = 1'b0;

        // Back to U, then delegated ecall to S
        do_xret(1'b0, 64'h0);
        check("mret2_redirect_pc", redirect_pc, 64'h1000);
        do_trap(1'b0, 6'd8, 64'h2004, 64'h0);
        check("ecall_redirect_pc", redirect_pc, 64'h4000_0000);
        check("ecall_pmode", pmode, 2'd1);
        check("ecall_mstatus_spp0", mstatus_o, 64'h80);
        check_csr("ecall_sepc", 12'h141, 64'h2004);
        check_csr("ecall_scause", 12'h142, 64'h8);
        check_csr("ecall_mepc_kept", 12'h341, 64'h1000);

        // mret from S is illegal; a second trap follows on the very next cycle
        do_xret(1'b0, 64'h5000);
        check("smret_pmode", pmode, 2'd3);
        check("smret_mstatus", mstatus_o, 64'h800);
        check("smret_redirect_pc", redirect_pc, 64'h8000_0000);
        check_csr("smret_mcause", 12'h342, 64'h2);
        check_csr("smret_mtval", 12'h343, 64'h0);
        do_trap(1'b0, 6'd3, 64'h6001, 64'h77);
        check("b2b_redirect_valid", redirect_valid, 1'b1);
        check("b2b_mstatus_mpp3", mstatus_o, 64'h1800);
        check_csr("b2b_mepc", 12'h341, 64'h6000);
        check_csr("b2b_mtval", 12'h343, 64'h77);

        // mret to S with MPP=1, MPIE=1; then sret to U; then illegal sret from U
        csr_write(12'h300, 64'h880);
        csr_write(12'h341, 64'h7000);
        do_xret(1'b0, 64'h0);
        check("mret_s_pmode", pmode, 2'd1);
        check("mret_s_mstatus", mstatus_o, 64'h88);
        check("mret_s_redirect_pc", redirect_pc, 64'h7000);
        do_xret(1'b1, 64'h0);
        check("sret_pmode", pmode, 2'd0);
        check("sret_mstatus", mstatus_o, 64'hA8);
        check("sret_redirect_pc", redirect_pc, 64'h2004);
        do_xret(1'b1, 64'h8000);
        check("usret_pmode", pmode, 2'd3);
        check("usret_mstatus", mstatus_o, 64'hA0);
        check_csr("usret_mcause", 12'h342, 64'h2);

        // M-level interrupt priority
        csr_write(12'h304, 64'h888);
        csr_write(12'h300, 64'h8);
        irq_timer = 1'b1; irq_soft = 1'b1;
        @(negedge clk); #1;
        check("prio_msi_over_mti", irq_code, 6'd3);
        irq_ext = 1'b1;
        @(negedge clk); #1;
        check("prio_mei_top", irq_code, 6'd11);
        csr_write(12'h300, 64'h0);
        check("m_mie0_pending", irq_pending, 1'b0);
        check("m_mie0_code", irq_code, 6'd0);
        irq_ext = 1'b0; irq_timer = 1'b0; irq_soft = 1'b0;

        // Delegated supervisor timer interrupt
        csr_write(12'h303, 64'hFFFF_FFFF_FFFF_FFFF);
        check_csr("mideleg_mask", 12'h303, 64'h222);
        csr_write(12'h304, 64'h20);
        csr_write(12'h344, 64'h20);
        csr_write(12'h300, 64'h8);
        check("s_irq_not_in_m", irq_pending, 1'b0);
        check_csr("sip_view", 12'h144, 64'h20);
        check_csr("sie_view", 12'h104, 64'h20);
        csr_write(12'h341, 64'h9000);
        do_xret(1'b0, 64'h0);
        check("sti_pending_in_u", irq_pending, 1'b1);
        check("sti_code", irq_code, 6'd5);
        do_trap(1'b1, 6'd5, 64'h9000, 64'h0);
        check("sti_pmode", pmode, 2'd1);
        check("sti_redirect_pc", redirect_pc, 64'h4000_0000);
        check("sti_masked_sie0", irq_pending, 1'b0);
        check_csr("sti_scause", 12'h142, 64'h8000_0000_0000_0005);

        // Asynchronous reset while a redirect is being presented
        do_trap(1'b0, 6'd2, 64'hA000, 64'h0);
        check("pre_rst_redirect", redirect_valid, 1'b1);
        rst = 1'b1; #1;
        check("mid_rst_redirect_valid", redirect_valid, 1'b0);
        check("mid_rst_redirect_pc", redirect_pc, 64'h0);
        check("mid_rst_pmode", pmode, 2'd3);
        check("mid_rst_mstatus", mstatus_o, 64'h0);
        check_csr("mid_rst_mtvec", 12'h305, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        check("post_rst_redirect", redirect_valid, 1'b0);
        check_csr("post_rst_mhartid", 12'hF14, 64'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
